tick_period_meter: RTL and testbench
====================================

# tick_period_meter

Measures the period, in `clk` cycles, between successive rising edges of a single-clock-domain tick input, such as the one-cycle strobe from the clock divider, and reports each result over a valid/ready handshake. It is the receiving end of the divider's tick. It lets the FFT control path and the bench confirm tick rate, detect a stopped tick and check period stability. Typical placement is directly on a divider output, with results consumed by a status register or a test monitor.

## Interface
- `periodBits`, default 20: width of the period counter and result. It must be at least `counterBits+1` of the driving divider to hold a 2^counterBits period.
- `clk`, in, 1: sole clock; all logic on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `tickIn`, in, 1: tick level, already in the `clk` domain; may be high for one or many cycles.
- `period`, out, `periodBits`: last captured period in cycles.
- `periodValid`, out, 1: `period` holds an unconsumed result.
- `periodReady`, in, 1: consumer accepts the result when high together with `periodValid`.
- `stable`, out, 1: the last two captured periods were equal.
- `timeout`, out, 1: sticky; the counter saturated with no edge.
- `overrun`, out, 1: sticky; a new result overwrote an unconsumed one.
- `clrFlags`, in, 1: clears `timeout` and `overrun`.

## Operation
- **Edge detect:** `rise = tickIn & ~tickPrev`. `tickPrev` is a register and resets to 0.
- **IDLE state:** entered at reset.
  - `cnt` is held at 0.
  - On `rise`, set `cnt <= 1` and go to MEASURE. No result is produced by this first edge.
- **MEASURE state:**
  - Each cycle, `cnt <= cnt + 1`.
  - On `rise`:
    - `period <= cnt`, `periodValid <= 1`.
    - `stable <= (cnt == prevPeriod)`, `prevPeriod <= cnt`.
    - `cnt <= 1`; stay in MEASURE.
- **Saturation:** if `cnt == 2^periodBits-1` and there is no `rise` in the same cycle:
  - `timeout <= 1`, `stable <= 0`, `prevPeriod <= 0`, `cnt <= 0`.
  - Go to IDLE.
  - `period` and `periodValid` are unchanged.
- **Edge at saturation:** a `rise` in the same cycle as `cnt == max` is a valid period equal to max. No timeout is raised.
- **Handshake:**
  - `periodValid` clears on the cycle after `periodValid & periodReady`.
  - `period` is stable while `periodValid` is high, unless it is overwritten.
- **Overrun:** a capture while `periodValid & ~periodReady` sets `overrun <= 1`.
  - The new `period` overwrites the old one and `periodValid` stays 1.
- **Accept and capture together:** a capture in the same cycle as an accept is not an overrun. `periodValid` stays 1 with the new value.
- **Flag clearing:** `clrFlags` clears the sticky flags.
  - If `clrFlags` coincides with a set event, the set wins.
- **Reset values:**
  - All outputs are 0: `period = 0`, `periodValid = 0`, `stable = 0`, `timeout = 0`, `overrun = 0`.
  - Internally, `cnt = 0`, `prevPeriod = 0`, `tickPrev = 0`, state IDLE.
- **Reset mid-measurement:** discards any partial count and pending result. The first edge after reset only arms the meter.

## Timing
- **Capture latency:** a `rise` seen at cycle t1 gives `period` and `periodValid` updated and visible at t1+1.
- **Period value:** with rises at t0 and t1, `period = t1 - t0`. The minimum achievable value is 2, since `tickIn` must go low between edges.
- **Level-held tick:** `tickIn` held high produces one rise only; the count continues until the next 0→1 transition.
- **Timeout latency:** `timeout` asserts 2^periodBits-1 cycles after the last rise, visible one cycle later.
- **Handshake timing:** there is no combinational path from `periodReady` to any output; all outputs are registered.

## Structure
- **Shared package (`fft_pkg`):**
  - the state enum (IDLE, MEASURE);
  - the `periodBits` default, tied to the divider's `counterBits` + 1.
- **Sub-module `rise_detect`:** holds the `tickPrev` register and produces `rise`. It is reused by other tick consumers.
- **Top module:** FSM, counter, capture, handshake and flag logic.

## Test plan
- **Divider-rate tick:** `periodBits=20`, one-cycle tick every 524288 cycles, `periodReady=1`.
  - First edge: no result.
  - Each later edge: `period=0x80000`; `stable=1` from the third edge on.
- **Back-pressure:** ticks every 10 cycles with `periodReady=0` for 25 cycles.
  - `period=10`, `periodValid` held, `overrun=1` after the second capture.
  - `clrFlags` clears `overrun`.
- **Timeout:** `periodBits=4`, first edge, then no tick.
  - `timeout=1` one cycle after 15 counted cycles; state returns to IDLE.
  - The next two edges 5 cycles apart give `period=5`.
- **Level-held tick:** `tickIn` high for 7 cycles, low for 3, repeating → `period=10`.
  - Ticks spaced 10 then 12 → `stable=0` after the 12 is captured.
- **Edge at saturation:** `periodBits=4`, edges exactly 15 cycles apart → `period=15`, `timeout=0`.
- **Reset mid-measure:** `rst_n=0` for one cycle 5 cycles after an edge.
  - All outputs read 0.
  - The next edge produces no result; the following edge yields the correct period.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT control path.
// Holds the tick-meter state encoding and the default period width, which
// is derived from the clock divider's counter width so that a full divider
// period (2^COUNTER_BITS cycles) fits in the period result.
package fft_pkg;

    // Width of the clock divider's counter.
    localparam int COUNTER_BITS = 19;

    // One extra bit so the meter can hold a period of exactly 2^COUNTER_BITS.
    localparam int PERIOD_BITS = COUNTER_BITS + 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a tick already in the clk domain.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   tickIn - tick level
//   rise   - high for the cycle in which tickIn goes 0 -> 1
// The previous-level register resets to 0, so a tick that is high when
// reset releases counts as a rising edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic tickIn,
    output logic rise
);

    logic r_tick_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_prev <= 1'b0;
        end else begin
            r_tick_prev <= tickIn;
        end
    end

    assign rise = tickIn & ~r_tick_prev;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the number of clk cycles between successive rising edges of
// tickIn and reports each period over a valid/ready handshake.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   tickIn      - tick level in the clk domain (one or many cycles high)
//   period      - last captured period in cycles
//   periodValid - period holds an unconsumed result
//   periodReady - consumer accepts the result
//   stable      - the last two captured periods were equal
//   timeout     - sticky: counter saturated without an edge
//   overrun     - sticky: a new result replaced an unconsumed one
//   clrFlags    - clears timeout and overrun (a coincident set wins)
//   o_state     - current FSM state, for observation only
// Handshake: a result transfers on every rising clk edge where periodValid
// and periodReady are both high; periodValid then drops on the next cycle
// unless a new capture happens on that same edge. periodValid never waits
// on periodReady and periodReady feeds no output combinationally.
module tick_period_meter
    import fft_pkg::*;
#(
    parameter int periodBits = PERIOD_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tickIn,
    output logic [periodBits-1:0] period,
    output logic                  periodValid,
    input  logic                  periodReady,
    output logic                  stable,
    output logic                  timeout,
    output logic                  overrun,
    input  logic                  clrFlags,
    output meter_state_t          o_state
);

    localparam logic [periodBits-1:0] CNT_MAX = '1;
    localparam logic [periodBits-1:0] CNT_ONE = {{(periodBits-1){1'b0}}, 1'b1};

    meter_state_t          r_state;
    logic [periodBits-1:0] r_cnt;
    logic [periodBits-1:0] r_prev_period;
    logic [periodBits-1:0] r_period;
    logic                  r_valid;
    logic                  r_stable;
    logic                  r_timeout;
    logic                  r_overrun;

    logic                  w_rise;
    logic                  w_accept;

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .tickIn (tickIn),
        .rise   (w_rise)
    );

    assign w_accept = r_valid & periodReady;

    // Clears are written first and sets later in the same block, so a set
    // event on the same edge overrides the clear by last-assignment order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_prev_period <= '0;
            r_period      <= '0;
            r_valid       <= 1'b0;
            r_stable      <= 1'b0;
            r_timeout     <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (clrFlags) begin
                r_timeout <= 1'b0;
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // The first edge only arms the meter; no result yet.
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= ST_MEASURE;
                    end
                end

                ST_MEASURE: begin
                    if (w_rise) begin
                        // An edge at cnt == max is still a valid period.
                        r_period      <= r_cnt;
                        r_valid       <= 1'b1;
                        r_stable      <= (r_cnt == r_prev_period);
                        r_prev_period <= r_cnt;
                        r_cnt         <= CNT_ONE;
                        // Replacing a result the consumer is not taking
                        // this edge loses it.
                        if (r_valid && !periodReady) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        // Tick stopped: drop back to waiting for an arming
                        // edge. Any pending result is left untouched.
                        r_timeout     <= 1'b1;
                        r_stable      <= 1'b0;
                        r_prev_period <= '0;
                        r_cnt         <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign period      = r_period;
    assign periodValid = r_valid;
    assign stable      = r_stable;
    assign timeout     = r_timeout;
    assign overrun     = r_overrun;
    assign o_state     = r_state;

endmodule

// File: tb/tb_tick_period_meter.sv
// Testbench for tick_period_meter. A narrow period width keeps timeout and
// saturation reachable in a short run. The driver issues one clk cycle of
// stimulus per step and advances a reference model built from edge
// timestamps: a period is the distance between two rising-edge cycle
// indices, a timeout is a gap of 2^PB-1 cycles with no edge. Results go to
// an expected queue that the monitor pops whenever the DUT transfers one.
module tb_tick_period_meter;
    import fft_pkg::*;

    localparam int PB  = 5;
    localparam int MAX = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tickIn;
    logic          periodReady;
    logic          clrFlags;
    logic [PB-1:0] period;
    logic          periodValid;
    logic          stable;
    logic          timeout;
    logic          overrun;
    meter_state_t  o_state;

    always #5 clk = ~clk;

    tick_period_meter #(.periodBits(PB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tickIn      (tickIn),
        .period      (period),
        .periodValid (periodValid),
        .periodReady (periodReady),
        .stable      (stable),
        .timeout     (timeout),
        .overrun     (overrun),
        .clrFlags    (clrFlags),
        .o_state     (o_state)
    );

    typedef struct {
        int per;
        bit st;
    } res_t;

    res_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit m_armed    = 1'b0;
    bit m_prev_lvl = 1'b0;
    int m_last     = 0;
    int m_t        = 0;
    int m_prev_per = 0;

    // Expected values after the upcoming edge, and after the last edge.
    bit to_n = 1'b0, ov_n = 1'b0, val_n = 1'b0, arm_n = 1'b0, rst_n_flag = 1'b0;
    bit to_c = 1'b0, ov_c = 1'b0, val_c = 1'b0, arm_c = 1'b0, rst_c = 1'b0;

    bit rdy_g = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Predict the effect of the upcoming edge given the inputs driven now.
    task automatic model(input bit tk, input bit rdy, input bit clr, input bit rst);
        bit   rise, pending, accept, cap, tmo, ovs;
        int   per;
        res_t r;
        if (!rst) begin
            exp_q.delete();
            m_armed    = 1'b0;
            m_prev_lvl = 1'b0;
            m_prev_per = 0;
            to_n       = 1'b0;
            ov_n       = 1'b0;
            val_n      = 1'b0;
            rst_n_flag = 1'b1;
        end else begin
            rst_n_flag = 1'b0;
            rise       = tk && !m_prev_lvl;
            m_prev_lvl = tk;
            pending    = val_n;
            accept     = pending && rdy;
            cap = 1'b0; tmo = 1'b0; ovs = 1'b0; per = 0;
            if (m_armed) begin
                if (rise) begin
                    cap    = 1'b1;
                    per    = m_t - m_last;
                    m_last = m_t;
                end else if (m_t - m_last == MAX) begin
                    tmo        = 1'b1;
                    m_armed    = 1'b0;
                    m_prev_per = 0;
                end
            end else if (rise) begin
                m_armed = 1'b1;
                m_last  = m_t;
            end
            if (cap) begin
                r.per      = per;
                r.st       = (per == m_prev_per);
                m_prev_per = per;
                if (pending && !rdy && exp_q.size() > 0) begin
                    ovs = 1'b1;
                    exp_q[exp_q.size()-1] = r;
                end else begin
                    exp_q.push_back(r);
                end
                val_n = 1'b1;
            end else if (accept) begin
                val_n = 1'b0;
            end
            // A pending result still waiting sees stable drop on timeout.
            if (tmo && pending && !accept && exp_q.size() > 0)
                exp_q[exp_q.size()-1].st = 1'b0;
            if (tmo)      to_n = 1'b1;
            else if (clr) to_n = 1'b0;
            if (ovs)      ov_n = 1'b1;
            else if (clr) ov_n = 1'b0;
        end
        arm_n = m_armed;
        m_t++;
    endtask

    task automatic step(input bit tk, input bit rdy, input bit clr, input bit rst);
        tickIn      = tk;
        periodReady = rdy;
        clrFlags    = clr;
        rst_n       = rst;
        model(tk, rdy, clr, rst);
        @(posedge clk);
        to_c  = to_n;
        ov_c  = ov_n;
        val_c = val_n;
        arm_c = arm_n;
        rst_c = rst_n_flag;
        #1;
    endtask

    // One rising edge, held high for hi cycles, then low for the rest of gap.
    task automatic pulse(input int gap, input int hi);
        for (int i = 0; i < gap; i++) step(i < hi, rdy_g, 1'b0, 1'b1);
    endtask

    // Monitor: compare registered outputs each cycle, pop on each transfer.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_c) begin
                chk("reset_period", int'(period), 0);
                chk("reset_stable", int'(stable), 0);
            end
            chk("valid", int'(periodValid), int'(val_c));
            chk("timeout", int'(timeout), int'(to_c));
            chk("overrun", int'(overrun), int'(ov_c));
            chk("state", int'(o_state), arm_c ? int'(ST_MEASURE) : int'(ST_IDLE));
            if (periodValid && periodReady && rst_n) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result at %0t: got period %0d expected none", $time, period);
                end else begin
                    e = exp_q.pop_front();
                    chk("period", int'(period), e.per);
                    chk("stable", int'(stable), int'(e.st));
                end
            end
        end
    end

    initial begin
        bit lvl, rdy, clr, rst;
        int quiet;
        tickIn = 1'b0; periodReady = 1'b1; clrFlags = 1'b0; rst_n = 1'b0;

        // Reset.
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Steady tick, consumer always ready: 10, 10, ... with stable.
        rdy_g = 1'b1;
        repeat (6) pulse(10, 1);

        // Back-pressure: results overwrite, overrun sets, clrFlags clears.
        rdy_g = 1'b0;
        repeat (3) pulse(10, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        rdy_g = 1'b1;
        repeat (3) pulse(10, 1);

        // Timeout after a lone edge, then re-arm with a 5-cycle tick.
        pulse(40, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (4) pulse(5, 1);

        // Level-held tick, then unequal spacing.
        repeat (4) pulse(10, 7);
        pulse(10, 1);
        pulse(12, 1);
        pulse(12, 1);

        // Edges exactly at saturation, then one cycle too late.
        repeat (4) pulse(MAX, 1);
        repeat (3) pulse(MAX + 1, 1);

        // Reset five cycles after an edge, then re-arm.
        pulse(5, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) pulse(10, 1);

        // Random traffic.
        lvl = 1'b0;
        quiet = 0;
        for (int i = 0; i < 4000; i++) begin
            if (quiet > 0) begin
                quiet--;
                lvl = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                quiet = $urandom_range(20, 45);
                lvl = 1'b0;
            end else if (lvl) begin
                lvl = ($urandom_range(0, 1) == 1);
            end else begin
                lvl = ($urandom_range(0, 14) == 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 499) != 0);
            step(lvl, rdy, clr, rst);
        end

        // Drain.
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
